// File: rtl/crossroad_pkg.sv
// Shared definitions for the crossroad light sequencer: state encoding,
// register map, light patterns and per-state helper functions.
package crossroad_pkg;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_NS_G  = 3'd1,
        ST_NS_Y  = 3'd2,
        ST_RED_A = 3'd3,
        ST_EW_G  = 3'd4,
        ST_EW_Y  = 3'd5,
        ST_RED_B = 3'd6,
        ST_FLASH = 3'd7
    } state_e;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_GREEN  = 2'd1;
    localparam logic [1:0] ADDR_YELLOW = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    // Light vectors are {red, yellow, green}.
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam logic [15:0] GREEN_DEFAULT  = 16'd5000;
    localparam logic [15:0] YELLOW_DEFAULT = 16'd2000;

    function automatic state_e next_in_cycle(state_e s);
        case (s)
            ST_NS_G:  return ST_NS_Y;
            ST_NS_Y:  return ST_RED_A;
            ST_RED_A: return ST_EW_G;
            ST_EW_G:  return ST_EW_Y;
            ST_EW_Y:  return ST_RED_B;
            default:  return ST_NS_G;
        endcase
    endfunction

    // Returns {ns, ew} for a state; blink only matters in FLASH.
    function automatic logic [5:0] lights_for(state_e s, logic blink);
        case (s)
            ST_NS_G:  return {GRN, RED};
            ST_NS_Y:  return {YEL, RED};
            ST_EW_G:  return {RED, GRN};
            ST_EW_Y:  return {RED, YEL};
            ST_FLASH: return {1'b0, blink, 1'b0, 1'b0, blink, 1'b0};
            default:  return {RED, RED};
        endcase
    endfunction

endpackage

// File: rtl/crossroad_switch_debounce.sv
// Two-flop synchroniser for the board switches followed by a per-bit
// tick-based debounce: a bit flips only after DEBOUNCE_TICKS stable ticks.
module crossroad_switch_debounce #(
    parameter int unsigned DEBOUNCE_TICKS = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic [1:0] raw,
    output logic [1:0] filt
);

    localparam int unsigned CW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;

    logic [1:0] sync1_q;
    logic [1:0] sync2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            // NOTE: non-blocking assignments let the two flops form a real chain.
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bit
        logic [CW-1:0] cnt_q;
        logic          filt_q;

        // Any tick where the input matches the filtered value restarts the count.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q  <= '0;
                filt_q <= 1'b0;
            end else if (sync2_q[b] == filt_q) begin
                cnt_q <= '0;
            end else if (tick) begin
                if (cnt_q == CW'(DEBOUNCE_TICKS - 1)) begin
                    filt_q <= sync2_q[b];
                    cnt_q  <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end

        assign filt[b] = filt_q;
    end

endmodule

// File: rtl/crossroad_light_sequencer.sv
// Avalon-MM traffic-light sequencer: tick prescaler, light FSM with phase
// timer, and the CTRL/GREEN_TIME/YELLOW_TIME/STATUS register file.
module crossroad_light_sequencer
    import crossroad_pkg::*;
#(
    parameter int unsigned TICK_DIV       = 50000,
    parameter int unsigned DEBOUNCE_TICKS = 20,
    parameter int unsigned RED_TICKS      = 1000,
    parameter int unsigned FLASH_TICKS    = 500
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic        read,
    output logic [31:0] readdata,
    input  logic [1:0]  in_port,
    output logic [2:0]  ns_lights,
    output logic [2:0]  ew_lights,
    output logic        irq
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] presc_q;
    logic          tick;
    logic [1:0]    sw_filt;
    logic [1:0]    ctrl_q;
    logic [15:0]   green_q;
    logic [15:0]   yellow_q;
    logic [31:0]   readdata_q;
    logic [31:0]   rd_mux;
    logic          status_wr;
    state_e        state_q;
    state_e        target;
    logic          go;
    logic          frozen;
    logic [15:0]   timer_q;
    logic [15:0]   dur_q;
    logic          blink_q;
    logic [2:0]    ns_q;
    logic [2:0]    ew_q;
    logic          irq_pend_q;
    logic          unused_wd;

    assign unused_wd = ^writedata[31:16];

    assign tick = (presc_q == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  presc_q <= '0;
        else if (tick) presc_q <= '0;
        else           presc_q <= presc_q + PW'(1);
    end

    crossroad_switch_debounce #(
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_debounce (
        .clk    (clk),
        .reset_n(reset_n),
        .tick   (tick),
        .raw    (in_port),
        .filt   (sw_filt)
    );

    // A programmed duration of 0 behaves as a single tick.
    function automatic logic [15:0] entry_dur(state_e s, logic [15:0] g, logic [15:0] y);
        logic [15:0] v;
        case (s)
            ST_NS_G, ST_EW_G: v = g;
            ST_NS_Y, ST_EW_Y: v = y;
            default:          v = 16'(RED_TICKS);
        endcase
        return (v == 16'd0) ? 16'd1 : v;
    endfunction

    assign frozen = sw_filt[1] && (state_q == ST_NS_G || state_q == ST_EW_G);

    always_comb begin
        // NOTE: defaults first so no path leaves go/target unassigned (no latches).
        go     = 1'b0;
        target = state_q;
        if (!ctrl_q[0]) begin
            go     = 1'b1;
            target = ST_OFF;
        end else if (sw_filt[0]) begin
            if (state_q != ST_FLASH) begin
                go     = 1'b1;
                target = ST_FLASH;
            end
        end else begin
            case (state_q)
                ST_OFF:   begin go = 1'b1; target = ST_NS_G;  end
                ST_FLASH: begin go = 1'b1; target = ST_RED_B; end
                default: begin
                    if (tick && !frozen && timer_q == dur_q - 16'd1) begin
                        go     = 1'b1;
                        target = next_in_cycle(state_q);
                    end
                end
            endcase
        end
    end

    assign status_wr = write && (address == ADDR_STATUS);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_OFF;
            timer_q    <= '0;
            dur_q      <= 16'd1;
            blink_q    <= 1'b0;
            ns_q       <= RED;
            ew_q       <= RED;
            irq_pend_q <= 1'b0;
        end else begin
            if (status_wr) irq_pend_q <= 1'b0;
            if (go) begin
                state_q <= target;
                timer_q <= '0;
                dur_q   <= entry_dur(target, green_q, yellow_q);
                if (target == ST_FLASH) begin
                    blink_q      <= 1'b1;
                    {ns_q, ew_q} <= lights_for(target, 1'b1);
                end else begin
                    {ns_q, ew_q} <= lights_for(target, blink_q);
                end
                // Placed after the clear so a same-cycle set takes priority.
                if (target == ST_NS_G) irq_pend_q <= 1'b1;
            end else if (tick) begin
                if (state_q == ST_FLASH) begin
                    if (timer_q == 16'(FLASH_TICKS - 1)) begin
                        timer_q      <= '0;
                        blink_q      <= !blink_q;
                        {ns_q, ew_q} <= lights_for(ST_FLASH, !blink_q);
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end else if (!frozen) begin
                    timer_q <= timer_q + 16'd1;
                end
            end
        end
    end

    always_comb begin
        case (address)
            ADDR_CTRL:   rd_mux = {30'd0, ctrl_q};
            ADDR_GREEN:  rd_mux = {16'd0, green_q};
            ADDR_YELLOW: rd_mux = {16'd0, yellow_q};
            default:     rd_mux = {26'd0, irq_pend_q, sw_filt, state_q};
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q     <= '0;
            green_q    <= GREEN_DEFAULT;
            yellow_q   <= YELLOW_DEFAULT;
            readdata_q <= '0;
        end else begin
            if (write) begin
                case (address)
                    ADDR_CTRL:   ctrl_q   <= writedata[1:0];
                    ADDR_GREEN:  green_q  <= writedata[15:0];
                    ADDR_YELLOW: yellow_q <= writedata[15:0];
                    default:     ;
                endcase
            end
            if (read) readdata_q <= rd_mux;
        end
    end

    assign readdata  = readdata_q;
    assign ns_lights = ns_q;
    assign ew_lights = ew_q;
    assign irq       = irq_pend_q & ctrl_q[1];

endmodule

// File: tb/tb_crossroad_light_sequencer.sv
// Directed bench for crossroad_light_sequencer with a 4-clock tick, 2-tick
// debounce, 2-tick red clearance and 3-tick flash half-period.
module tb_crossroad_light_sequencer;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] D = 3'b000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = '0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic        read = 1'b0;
    logic [31:0] readdata;
    logic [1:0]  in_port = '0;
    logic [2:0]  ns_lights;
    logic [2:0]  ew_lights;
    logic        irq;

    int checks = 0;
    int failures = 0;

    crossroad_light_sequencer #(
        .TICK_DIV(4), .DEBOUNCE_TICKS(2), .RED_TICKS(2), .FLASH_TICKS(3)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .write(write),
        .writedata(writedata), .read(read), .readdata(readdata),
        .in_port(in_port), .ns_lights(ns_lights), .ew_lights(ew_lights), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        step();
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a; read = 1'b1;
        step();
        read = 1'b0;
        d = readdata;
    endtask

    task automatic wait_for(input logic [2:0] ns, input logic [2:0] ew, input int max, input string name);
        int n = 0;
        while (!(ns_lights === ns && ew_lights === ew) && n < max) begin
            step();
            n++;
        end
        checks++;
        if (n >= max) begin
            failures++;
            $display("FAIL %s: timeout after %0d cycles, lights ns=%b ew=%b wanted ns=%b ew=%b",
                     name, n, ns_lights, ew_lights, ns, ew);
        end
    endtask

    // Cycles until the lights leave the given pattern.
    task automatic measure(input logic [2:0] ns, input logic [2:0] ew, input int max, output int n);
        n = 0;
        while (ns_lights === ns && ew_lights === ew && n < max) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset_n = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        step();
        checks++; if (readdata !== 32'd0) begin failures++; $display("FAIL reset_readdata got=%0h want=0", readdata); end
        checks++; if (ns_lights !== R || ew_lights !== R) begin failures++; $display("FAIL reset_lights got ns=%b ew=%b want 100/100", ns_lights, ew_lights); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b want=0", irq); end
        bus_read(2'd3, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_status got=%0h want=0", d); end
        bus_read(2'd1, d);
        checks++; if (d !== 32'd5000) begin failures++; $display("FAIL reset_green got=%0d want=5000", d); end
        bus_read(2'd2, d);
        checks++; if (d !== 32'd2000) begin failures++; $display("FAIL reset_yellow got=%0d want=2000", d); end
        bus_read(2'd0, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_ctrl got=%0h want=0", d); end
    endtask

    task automatic test_registers();
        logic [31:0] d;
        address = 2'd1; writedata = 32'hABCD_0003; write = 1'b1; read = 1'b1;
        step();
        write = 1'b0; read = 1'b0;
        checks++; if (readdata !== 32'd5000) begin failures++; $display("FAIL rw_same_cycle got=%0d want=5000", readdata); end
        bus_read(2'd1, d);
        checks++; if (d !== 32'd3) begin failures++; $display("FAIL green_upper_bits got=%0h want=3", d); end
        bus_write(2'd2, 32'd1);
    endtask

    task automatic test_normal_cycle();
        int n;
        logic [31:0] d;
        bus_write(2'd0, 32'd3);
        step();
        checks++; if (ns_lights !== G || ew_lights !== R) begin failures++; $display("FAIL enable_ns_g got ns=%b ew=%b want 001/100", ns_lights, ew_lights); end
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL enable_irq got=%b want=1", irq); end
        measure(G, R, 100, n);
        checks++; if (n < 9 || n > 12) begin failures++; $display("FAIL ns_g_first_len got=%0d want 9..12", n); end
        measure(Y, R, 100, n);
        checks++; if (n !== 4) begin failures++; $display("FAIL ns_y_len got=%0d want=4", n); end
        measure(R, R, 100, n);
        checks++; if (n !== 8) begin failures++; $display("FAIL red_a_len got=%0d want=8", n); end
        checks++; if (ns_lights !== R || ew_lights !== G) begin failures++; $display("FAIL ew_g_entry got ns=%b ew=%b want 100/001", ns_lights, ew_lights); end
        bus_write(2'd3, 32'd0);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b want=0", irq); end
        bus_read(2'd3, d);
        checks++; if (d !== 32'd4) begin failures++; $display("FAIL status_ew_g got=%0h want=4", d); end
    endtask

    task automatic test_flash();
        int n;
        logic saw_flash = 1'b0;
        logic [31:0] d;
        in_port[0] = 1'b1;
        repeat (4) step();
        in_port[0] = 1'b0;
        for (int i = 0; i < 24; i++) begin
            step();
            if ((ns_lights === Y && ew_lights === Y) || (ns_lights === D && ew_lights === D)) saw_flash = 1'b1;
        end
        checks++; if (saw_flash !== 1'b0) begin failures++; $display("FAIL short_pulse_flash got=1 want=0"); end
        bus_read(2'd3, d);
        checks++; if (d[4:3] !== 2'b00) begin failures++; $display("FAIL short_pulse_sw_filt got=%b want=00", d[4:3]); end
        in_port[0] = 1'b1;
        wait_for(Y, Y, 40, "flash_entry");
        measure(Y, Y, 100, n);
        checks++; if (n < 9 || n > 12) begin failures++; $display("FAIL flash_first_on got=%0d want 9..12", n); end
        measure(D, D, 100, n);
        checks++; if (n !== 12) begin failures++; $display("FAIL flash_off_len got=%0d want=12", n); end
        measure(Y, Y, 100, n);
        checks++; if (n !== 12) begin failures++; $display("FAIL flash_on_len got=%0d want=12", n); end
        bus_write(2'd3, 32'd0);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL flash_irq_clear got=%b want=0", irq); end
        in_port[0] = 1'b0;
        wait_for(R, R, 40, "flash_exit_red_b");
        measure(R, R, 100, n);
        checks++; if (n < 5 || n > 8) begin failures++; $display("FAIL red_b_len got=%0d want 5..8", n); end
        checks++; if (ns_lights !== G || ew_lights !== R) begin failures++; $display("FAIL resume_ns_g got ns=%b ew=%b want 001/100", ns_lights, ew_lights); end
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL resume_irq got=%b want=1", irq); end
    endtask

    task automatic test_green_hold();
        int n = 0;
        bus_write(2'd1, 32'd6);
        wait_for(R, G, 100, "hold_ew_g_entry");
        in_port[1] = 1'b1;
        while (ns_lights === R && ew_lights === G && n < 300) begin
            if (n == 80) in_port[1] = 1'b0;
            step();
            n++;
        end
        in_port[1] = 1'b0;
        checks++; if (n !== 104) begin failures++; $display("FAIL hold_ew_g_len got=%0d want=104", n); end
        checks++; if (ns_lights !== R || ew_lights !== Y) begin failures++; $display("FAIL hold_exit_ew_y got ns=%b ew=%b want 100/010", ns_lights, ew_lights); end
    endtask

    task automatic test_green_update();
        int n;
        bus_write(2'd1, 32'd0);
        wait_for(G, R, 100, "zero_green_ns_g_entry");
        bus_write(2'd1, 32'd10);
        measure(G, R, 100, n);
        checks++; if (n + 1 !== 4) begin failures++; $display("FAIL zero_green_len got=%0d want=4", n + 1); end
        measure(Y, R, 100, n);
        checks++; if (n !== 4) begin failures++; $display("FAIL upd_ns_y_len got=%0d want=4", n); end
        measure(R, R, 100, n);
        checks++; if (n !== 8) begin failures++; $display("FAIL upd_red_a_len got=%0d want=8", n); end
        measure(R, G, 100, n);
        checks++; if (n !== 40) begin failures++; $display("FAIL new_green_ew_g_len got=%0d want=40", n); end
    endtask

    task automatic test_disable_and_reset();
        logic [31:0] d;
        bus_write(2'd0, 32'd2);
        checks++; if (ns_lights !== R || ew_lights !== Y) begin failures++; $display("FAIL pre_disable_ew_y got ns=%b ew=%b want 100/010", ns_lights, ew_lights); end
        step();
        checks++; if (ns_lights !== R || ew_lights !== R) begin failures++; $display("FAIL disable_lights got ns=%b ew=%b want 100/100", ns_lights, ew_lights); end
        bus_read(2'd3, d);
        checks++; if (d !== 32'h20) begin failures++; $display("FAIL disable_status got=%0h want=20", d); end
        bus_write(2'd0, 32'd3);
        step();
        checks++; if (ns_lights !== G || ew_lights !== R) begin failures++; $display("FAIL reenable_ns_g got ns=%b ew=%b want 001/100", ns_lights, ew_lights); end
        bus_read(2'd3, d);
        checks++; if (d !== 32'h21) begin failures++; $display("FAIL reenable_status got=%0h want=21", d); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (ns_lights !== R || ew_lights !== R) begin failures++; $display("FAIL async_reset_lights got ns=%b ew=%b want 100/100", ns_lights, ew_lights); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL async_reset_irq got=%b want=0", irq); end
        checks++; if (readdata !== 32'd0) begin failures++; $display("FAIL async_reset_readdata got=%0h want=0", readdata); end
        step();
        reset_n = 1'b1;
        step();
        bus_read(2'd1, d);
        checks++; if (d !== 32'd5000) begin failures++; $display("FAIL post_reset_green got=%0d want=5000", d); end
        bus_read(2'd0, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL post_reset_ctrl got=%0h want=0", d); end
    endtask

    initial begin
        test_reset();
        test_registers();
        test_normal_cycle();
        test_flash();
        test_green_hold();
        test_green_update();
        test_disable_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
